// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives every W combination into a combinational
// function block and captures f into a truth table plus a ones count.
// Optional build macro TT_COMPARE_EN adds the Expected input and Match output.
module truth_table_scanner #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 f,
`ifdef TT_COMPARE_EN
    input  logic [2**N_IN-1:0]   Expected,
    output logic                 Match,
`endif
    output logic                 En,
    output logic [N_IN-1:0]      W,
    output logic                 Busy,
    output logic                 Done,
    output logic [2**N_IN-1:0]   TT,
    output logic [N_IN:0]        Count
);

    localparam logic [N_IN-1:0] W_LAST   = '1;
    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [3:0]           settle;
    logic                 sample;
    logic                 last;
    logic [2**N_IN-1:0]   tt_next;

    // f is taken on the final settle cycle of each index
    assign sample = !(settle < SETTLE_L);
    assign last   = sample && (W == W_LAST);

    // truth table with the current sample merged in
    always_comb begin
        tt_next    = TT;
        tt_next[W] = f;
    end

    // state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state decode
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // status outputs decoded from the state
    always_comb begin
        En   = 1'b0;
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state)
            SCAN: begin
                En   = 1'b1;
                Busy = 1'b1;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // W stepping, settle counting and result capture
    always_ff @(posedge Clock) begin
        if (Reset) begin
            W      <= '0;
            TT     <= '0;
            Count  <= '0;
            settle <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        W      <= '0;
                        TT     <= '0;
                        Count  <= '0;
                        settle <= '0;
                    end
                end
                SCAN: begin
                    if (!sample) begin
                        settle <= settle + 4'd1;
                    end else begin
                        TT     <= tt_next;
                        Count  <= Count + {{N_IN{1'b0}}, f};
                        settle <= '0;
                        // W parks at 0 while DONE is shown
                        if (W == W_LAST) begin
                            W <= '0;
                        end else begin
                            W <= W + 1'b1;
                        end
                    end
                end
                DONE: begin
                    W <= '0;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef TT_COMPARE_EN
    // compare the completed table on the edge that enters DONE
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Match <= 1'b0;
        end else if (state == IDLE && Start) begin
            Match <= 1'b0;
        end else if (state == SCAN && last) begin
            Match <= (tt_next == Expected);
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: vector table, hand-written corner
// sequences and random functions checked against a minterm-set model.
module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] func0 = '0;
    logic [15:0] func2 = '0;
    logic        f0, f2;
    logic        en0, en2, busy0, busy2, done0, done2;
    logic [3:0]  w0, w2;
    logic [15:0] tt0, tt2;
    logic [4:0]  cnt0, cnt2;
    logic [15:0] expected0 = 16'hC2CA;
    logic        match0, match2;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    logic        m_en, m_busy, m_done;
    logic [3:0]  m_w;
    logic [15:0] m_tt;
    logic [4:0]  m_cnt;

    always #5 clk = ~clk;

    assign f0 = en0 & func0[w0];
    assign f2 = en2 & func2[w2];

    truth_table_scanner #(.N_IN(4), .SETTLE(0)) dut0 (
        .Clock(clk), .Reset(rst), .Start(start0), .f(f0),
`ifdef TT_COMPARE_EN
        .Expected(expected0), .Match(match0),
`endif
        .En(en0), .W(w0), .Busy(busy0), .Done(done0),
        .TT(tt0), .Count(cnt0)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(2)) dut2 (
        .Clock(clk), .Reset(rst), .Start(start2), .f(f2),
`ifdef TT_COMPARE_EN
        .Expected(func2), .Match(match2),
`endif
        .En(en2), .W(w2), .Busy(busy2), .Done(done2),
        .TT(tt2), .Count(cnt2)
    );

`ifndef TT_COMPARE_EN
    assign match0 = 1'b0;
    assign match2 = 1'b0;
`endif

    always_comb begin
        m_en   = sel != 0 ? en2   : en0;
        m_busy = sel != 0 ? busy2 : busy0;
        m_done = sel != 0 ? done2 : done0;
        m_w    = sel != 0 ? w2    : w0;
        m_tt   = sel != 0 ? tt2   : tt0;
        m_cnt  = sel != 0 ? cnt2  : cnt0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic drv_start(input logic v);
        if (sel != 0) start2 = v;
        else start0 = v;
    endtask

    function automatic int ones(input logic [15:0] v);
        int n = 0;
        for (int k = 0; k < 16; k++) n += int'(v[k]);
        return n;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en0"}, en0, 0);
        chk({tag, "_w0"}, w0, 0);
        chk({tag, "_busy0"}, busy0, 0);
        chk({tag, "_done0"}, done0, 0);
        chk({tag, "_tt0"}, tt0, 0);
        chk({tag, "_cnt0"}, cnt0, 0);
        chk({tag, "_busy2"}, busy2, 0);
        chk({tag, "_tt2"}, tt2, 0);
        chk({tag, "_cnt2"}, cnt2, 0);
`ifdef TT_COMPARE_EN
        chk({tag, "_match0"}, match0, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        @(negedge clk);
        chk_reset_vals({tag, "_r1"});
        @(negedge clk);
        chk_reset_vals({tag, "_r2"});
        rst = 1'b0;
    endtask

    // full scan on the selected instance; s is its SETTLE value
    task automatic scan(input int s, input logic [15:0] exp_tt,
                        input int exp_cnt, input bit poke);
        int len = 16 * (s + 1);
        @(negedge clk);
        drv_start(1'b1);
        @(negedge clk);
        drv_start(1'b0);
        chk("tt_clear", m_tt, 0);
        chk("cnt_clear", m_cnt, 0);
`ifdef TT_COMPARE_EN
        if (sel == 0) chk("match_clear", match0, 0);
`endif
        for (int c = 1; c <= len; c++) begin
            chk("scan_busy", m_busy, 1);
            chk("scan_en", m_en, 1);
            chk("scan_done", m_done, 0);
            chk("scan_w", m_w, (c - 1) / (s + 1));
            drv_start(poke && c == 5 * (s + 1) + 1);
            @(negedge clk);
        end
        chk("done_pulse", m_done, 1);
        chk("done_busy", m_busy, 0);
        chk("done_en", m_en, 0);
        chk("done_w", m_w, 0);
        chk("done_tt", m_tt, exp_tt);
        chk("done_cnt", m_cnt, exp_cnt);
`ifdef TT_COMPARE_EN
        if (sel == 0) chk("match", match0, exp_tt == expected0);
`endif
        drv_start(poke);
        @(negedge clk);
        chk("idle_done", m_done, 0);
        chk("idle_busy", m_busy, 0);
        chk("idle_tt", m_tt, exp_tt);
        chk("idle_cnt", m_cnt, exp_cnt);
        if (poke) begin
            @(negedge clk);
            drv_start(1'b0);
            chk("restart_busy", m_busy, 1);
            chk("restart_w", m_w, 0);
            chk("restart_tt", m_tt, 0);
`ifdef TT_COMPARE_EN
            if (sel == 0) chk("restart_match", match0, 0);
`endif
            do_reset("post_poke");
        end
    endtask

    typedef struct {
        logic [15:0] func;
        int          s;
        logic [15:0] exp_tt;
        int          exp_cnt;
        bit          poke;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [15:0] mt;
        logic [15:0] r;
        int mins[7] = '{1, 3, 6, 7, 9, 14, 15};
        mt = '0;
        foreach (mins[i]) mt[mins[i]] = 1'b1;

        tbl[0] = '{mt,       0, 16'hC2CA, 7,  1'b0};
        tbl[1] = '{16'hFFFF, 2, 16'hFFFF, 16, 1'b0};
        tbl[2] = '{mt,       0, 16'hC2CA, 7,  1'b1};
        tbl[3] = '{16'h0000, 0, 16'h0000, 0,  1'b0};
        tbl[4] = '{16'h8001, 2, 16'h8001, 2,  1'b0};
        tbl[5] = '{16'hFFFF, 0, 16'hFFFF, 16, 1'b0};

        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        foreach (tbl[i]) begin
            sel = tbl[i].s != 0 ? 1 : 0;
            if (sel != 0) func2 = tbl[i].func;
            else func0 = tbl[i].func;
            scan(tbl[i].s, tbl[i].exp_tt, tbl[i].exp_cnt, tbl[i].poke);
        end

        // reset while W=9 aborts with no Done pulse
        sel = 0;
        func0 = mt;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_w9", w0, 9);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("abort1");
        @(negedge clk);
        chk_reset_vals("abort2");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("abort_no_done", done0, 0);
            chk("abort_idle", busy0, 0);
        end
        scan(0, 16'hC2CA, 7, 1'b0);

`ifdef TT_COMPARE_EN
        expected0 = 16'hC2CB;
        scan(0, 16'hC2CA, 7, 1'b0);
        expected0 = 16'hC2CA;
        scan(0, 16'hC2CA, 7, 1'b0);
`endif

        // random functions against the minterm-set model
        for (int n = 0; n < 10; n++) begin
            r = 16'($urandom);
            sel = n % 3 == 2 ? 1 : 0;
            if (sel != 0) func2 = r;
            else func0 = r;
            expected0 = ($urandom_range(1) != 0) ? r : r ^ 16'h0100;
            scan(sel != 0 ? 2 : 0, r, ones(r), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
